instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word fetches and
// buffers in-order responses for the decoder; a redirect flushes and drops stale data.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);
  // state | meaning
  // IDLE  | first cycle after reset release, no requests
  // FETCH | normal operation, requests issued while credit remains
  // DRAIN | stale responses still in flight after a redirect, no requests

  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   outstanding_nxt;
  logic [CNT_W:0]     credit_used;
  logic [INSTR_W-1:0] data_q   [DEPTH];
  logic [ADDR_W-1:0]  pc_q     [DEPTH];
  logic [ADDR_W-1:0]  req_pc_q [DEPTH];
  logic [PTR_W-1:0]   head, tail, rq_head, rq_tail;
  logic               req_fire, rsp_ok, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit covers both in-flight requests and buffered entries, so the FIFO cannot overflow.
  assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid  = (state == FETCH) && (credit_used < DEPTH_C) && !redirect_valid;
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp_ok          = imem_rsp_valid && (outstanding != '0);
  assign push            = rsp_ok && (drop_cnt == '0) && !redirect_valid;
  assign pop             = ir_valid && ir_ready;
  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_ok);

  assign ir_valid = (fifo_count != '0);
  assign ir_data  = data_q[head];
  assign ir_pc    = pc_q[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      head        <= '0;
      tail        <= '0;
      rq_head     <= '0;
      rq_tail     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]   <= '0;
        pc_q[i]     <= '0;
        req_pc_q[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;

      if (req_fire) begin
        req_pc_q[rq_tail] <= pc;
        rq_tail           <= ptr_inc(rq_tail);
      end
      if (rsp_ok) rq_head <= ptr_inc(rq_head);

      if (push) begin
        data_q[tail] <= imem_rsp_data;
        pc_q[tail]   <= req_pc_q[rq_head];
      end

      if (redirect_valid) begin
        // Everything still in flight after this cycle's response is stale.
        pc         <= redirect_pc;
        drop_cnt   <= outstanding_nxt;
        fifo_count <= '0;
        head       <= '0;
        tail       <= '0;
      end else begin
        if (req_fire) pc <= pc + ADDR_W'(1);
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
        if (push) tail <= ptr_inc(tail);
        if (pop) head <= ptr_inc(head);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end

      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (redirect_valid && (outstanding_nxt != '0)) state <= DRAIN;
        DRAIN:   if (!redirect_valid && (drop_cnt == '0)) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
